io_arbiter: RTL and testbench

Two-master arbiter and sequencer for the 8-bit memory-mapped IO register bus. It sits between two bus masters and the IO peripheral's port: master 0 is the CPU load/store unit, master 1 is a secondary requester such as a debug or loader engine. It serialises their read and write requests into single-cycle `w_en`/`r_en` strobes. It returns read data, which the peripheral registers one cycle after `r_en`.

---
 rtl/io_arbiter.sv | 119 +++++++++++
 tb/tb_io_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_arbiter.sv
// Two-master arbiter/sequencer for the 8-bit IO register bus: IDLE -> ISSUE -> ACK.
// Define IO_ARBITER_FIXED_PRIO_EN for fixed priority (master 0 wins); default is round-robin.
module io_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] io_address,
    output logic [DATA_W-1:0] io_din,
    output logic              io_w_en,
    output logic              io_r_en,
    input  logic [DATA_W-1:0] io_dout,
    output logic              grant
);

    typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;

    state_t                   state, state_nxt;
    logic [1:0]               req, we;
    logic [1:0][ADDR_W-1:0]   addr;
    logic [1:0][DATA_W-1:0]   wdata;
    logic [1:0][DATA_W-1:0]   rdata_q, rdata_nxt;
    logic [1:0]               ack_q, ack_nxt;
    logic [ADDR_W-1:0]        addr_nxt;
    logic [DATA_W-1:0]        din_nxt;
    logic                     w_nxt, r_nxt, rd_q, rd_nxt, grant_nxt, win;

    assign req   = {m1_req, m0_req};
    assign we    = {m1_we, m0_we};
    assign addr  = {m1_addr, m0_addr};
    assign wdata = {m1_wdata, m0_wdata};

`ifdef IO_ARBITER_FIXED_PRIO_EN
    assign win = ~req[0];
`else
    // Contended: the master that did not win last time goes next.
    assign win = (&req) ? ~grant : req[1];
`endif

    always_comb begin
        state_nxt = state;
        addr_nxt  = io_address;
        din_nxt   = io_din;
        w_nxt     = 1'b0;
        r_nxt     = 1'b0;
        rd_nxt    = rd_q;
        grant_nxt = grant;
        ack_nxt   = '0;
        rdata_nxt = rdata_q;
        case (state)
            IDLE: begin
                if (|req) begin
                    addr_nxt  = addr[win];
                    din_nxt   = wdata[win];
                    w_nxt     = we[win];
                    r_nxt     = ~we[win];
                    rd_nxt    = ~we[win];
                    grant_nxt = win;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                ack_nxt[grant] = 1'b1;
                state_nxt      = ACK;
            end
            ACK: begin
                if (rd_q) rdata_nxt[grant] = io_dout;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            io_address <= '0;
            io_din     <= '0;
            io_w_en    <= 1'b0;
            io_r_en    <= 1'b0;
            rd_q       <= 1'b0;
            grant      <= 1'b1;
            ack_q      <= '0;
            rdata_q    <= '0;
        end else begin
            state      <= state_nxt;
            io_address <= addr_nxt;
            io_din     <= din_nxt;
            io_w_en    <= w_nxt;
            io_r_en    <= r_nxt;
            rd_q       <= rd_nxt;
            grant      <= grant_nxt;
            ack_q      <= ack_nxt;
            rdata_q    <= rdata_nxt;
        end
    end

    assign m0_ack = ack_q[0];
    assign m1_ack = ack_q[1];

    // The peripheral's dout only lands in the ACK cycle, so forward it during ack
    // and keep the captured copy afterwards.
    assign m0_rdata = (ack_q[0] && rd_q) ? io_dout : rdata_q[0];
    assign m1_rdata = (ack_q[1] && rd_q) ? io_dout : rdata_q[1];

endmodule

// File: tb/tb_io_arbiter.sv
// Scoreboard bench for io_arbiter: directed stimulus pushes expected strobes/acks,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_io_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [7:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
    logic       m0_ack, m1_ack, io_w_en, io_r_en, grant;
    logic [7:0] m0_rdata, m1_rdata, io_address, io_din;
    logic [7:0] io_dout = 0;
    logic [7:0] mem [256];

    int total = 0;
    int bad   = 0;

    typedef struct { logic we; logic [7:0] addr; logic [7:0] din; } strb_t;
    typedef struct { logic m; logic rd; logic [7:0] rdata; } ack_t;
    strb_t strb_q[$];
    ack_t  ack_q[$];
    logic  prev_strb = 1'b0;

    io_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .io_address(io_address), .io_din(io_din), .io_w_en(io_w_en), .io_r_en(io_r_en),
        .io_dout(io_dout), .grant(grant)
    );

    always #5 clk = ~clk;

    // Peripheral: registered read data one cycle after io_r_en.
    always @(posedge clk) begin
        if (io_w_en) mem[io_address] <= io_din;
        if (io_r_en) io_dout <= mem[io_address];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_txn(input logic m, input logic w, input logic [7:0] a,
                              input logic [7:0] d, input logic [7:0] rdat);
        strb_t s;
        ack_t  k;
        s.we = w; s.addr = a; s.din = d;
        k.m = m; k.rd = ~w; k.rdata = rdat;
        strb_q.push_back(s);
        ack_q.push_back(k);
    endtask

    task automatic wait_ack(input int m, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!((m == 0) ? m0_ack : m1_ack) && n < 20);
        if (!((m == 0) ? m0_ack : m1_ack)) chk("ack_timeout", 0, 1);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_strb = 1'b0;
        end else begin
            if (io_w_en || io_r_en) begin
                chk("one_strobe", {31'd0, io_w_en && io_r_en}, 0);
                chk("strobe_gap", {31'd0, prev_strb}, 0);
                if (strb_q.size() == 0) chk("extra_strobe", 1, 0);
                else begin
                    strb_t s;
                    s = strb_q.pop_front();
                    chk("strobe_we", {31'd0, io_w_en}, {31'd0, s.we});
                    chk("io_address", {24'd0, io_address}, {24'd0, s.addr});
                    chk("io_din", {24'd0, io_din}, {24'd0, s.din});
                end
            end
            if (m0_ack || m1_ack) begin
                chk("one_ack", {31'd0, m0_ack && m1_ack}, 0);
                chk("ack_after_strobe", {31'd0, prev_strb}, 1);
                if (ack_q.size() == 0) chk("extra_ack", 1, 0);
                else begin
                    ack_t k;
                    k = ack_q.pop_front();
                    chk("ack_master", {31'd0, m1_ack}, {31'd0, k.m});
                    chk("grant", {31'd0, grant}, {31'd0, k.m});
                    if (k.rd)
                        chk("rdata", {24'd0, (k.m ? m1_rdata : m0_rdata)}, {24'd0, k.rdata});
                end
            end
            prev_strb = io_w_en || io_r_en;
        end
    end

    initial begin
        int n;
        int acks;
        int idx;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h06] = 8'h3C;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_w_en", {31'd0, io_w_en}, 0);
        chk("rst_r_en", {31'd0, io_r_en}, 0);
        chk("rst_acks", {30'd0, m1_ack, m0_ack}, 0);
        chk("rst_rdata", {16'd0, m1_rdata, m0_rdata}, 0);
        chk("rst_addr", {24'd0, io_address}, 0);
        chk("rst_grant", {31'd0, grant}, 1);
        rst = 1'b0;
        @(negedge clk);

        // Single master-0 write
        m0_we = 1; m0_addr = 8'h01; m0_wdata = 8'hA5; m0_req = 1;
        expect_txn(0, 1, 8'h01, 8'hA5, 8'h00);
        wait_ack(0, n);
        chk("m0_wr_latency", n, 2);
        chk("m1_ack_idle", {31'd0, m1_ack}, 0);
        m0_req = 0;
        @(negedge clk);

        // Master-1 read of 0x06
        m1_we = 0; m1_addr = 8'h06; m1_wdata = 8'h00; m1_req = 1;
        expect_txn(1, 0, 8'h06, 8'h00, 8'h3C);
        wait_ack(1, n);
        chk("m1_rd_latency", n, 2);
        chk("m0_rdata_kept", {24'd0, m0_rdata}, 0);
        m1_req = 0;
        @(negedge clk);
        chk("m1_rdata_held", {24'd0, m1_rdata}, 32'h3C);

        // Contention from reset: six transactions
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m0_we = 1; m0_addr = 8'h10; m0_wdata = 8'h11;
        m1_we = 1; m1_addr = 8'h20; m1_wdata = 8'h22;
        for (int i = 0; i < 6; i++) begin
`ifdef IO_ARBITER_FIXED_PRIO_EN
            expect_txn(0, 1, 8'h10, 8'h11, 8'h00);
`else
            if (i % 2 == 0) expect_txn(0, 1, 8'h10, 8'h11, 8'h00);
            else            expect_txn(1, 1, 8'h20, 8'h22, 8'h00);
`endif
        end
        m0_req = 1; m1_req = 1;
        acks = 0; idx = 0;
        while (acks < 6 && idx < 40) begin
            @(negedge clk);
            idx++;
            if (m0_ack || m1_ack) acks++;
        end
        chk("contend_acks", acks, 6);
        m0_req = 0; m1_req = 0;
        @(negedge clk);

        // m1_req rises during master-0 ISSUE
        m0_we = 1; m0_addr = 8'h40; m0_wdata = 8'h44; m0_req = 1;
        m1_we = 1; m1_addr = 8'h30; m1_wdata = 8'h33;
        expect_txn(0, 1, 8'h40, 8'h44, 8'h00);
        expect_txn(1, 1, 8'h30, 8'h33, 8'h00);
        @(negedge clk);
        chk("m0_issue_seen", {31'd0, io_w_en}, 1);
        m1_req = 1;
        wait_ack(0, n);
        chk("m0_before_m1", n, 1);
        m0_req = 0;
        wait_ack(1, n);
        chk("m1_waits", n, 3);
        m1_req = 0;
        @(negedge clk);

        // Reset in the ISSUE cycle of a write
        m0_we = 1; m0_addr = 8'h02; m0_wdata = 8'h5A; m0_req = 1;
        begin
            strb_t s;
            s.we = 1; s.addr = 8'h02; s.din = 8'h5A;
            strb_q.push_back(s);
        end
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("arst_w_en", {31'd0, io_w_en}, 0);
        chk("arst_acks", {30'd0, m1_ack, m0_ack}, 0);
        chk("arst_addr", {24'd0, io_address}, 0);
        chk("arst_din", {24'd0, io_din}, 0);
        chk("arst_grant", {31'd0, grant}, 1);
        repeat (2) @(negedge clk);
        chk("arst_no_ack", {30'd0, m1_ack, m0_ack}, 0);
        rst = 1'b0;
        expect_txn(0, 1, 8'h02, 8'h5A, 8'h00);
        wait_ack(0, n);
        chk("restart_latency", n, 2);
        m0_req = 0;
        @(negedge clk);

        // Master 0 holds req across ack: second identical write
        m0_we = 1; m0_addr = 8'h03; m0_wdata = 8'h77; m0_req = 1;
        expect_txn(0, 1, 8'h03, 8'h77, 8'h00);
        expect_txn(0, 1, 8'h03, 8'h77, 8'h00);
        wait_ack(0, n);
        chk("hold_first", n, 2);
        wait_ack(0, n);
        chk("hold_second", n, 3);
        m0_req = 0;

        repeat (4) @(negedge clk);
        chk("strb_q_empty", strb_q.size(), 0);
        chk("ack_q_empty", ack_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
